// File: rtl/cnn_pkg.sv
// Shared CNN constants, coefficient address map, FSM state type and the
// saturation helper reused by the later layers.
package cnn_pkg;

    localparam int CNN_IMG_W    = 28;
    localparam int CNN_IMG_H    = 28;
    localparam int CNN_CONV_DW  = 20;
    localparam int CNN_NUM_FILT = 4;
    localparam int CNN_NUM_TAPS = 9;

    // Coefficient address map: 0..8 are kernel taps k[r][c] at r*3+c.
    localparam logic [3:0] CNN_ADDR_BIAS = 4'd9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } conv_state_t;

    // Clamp a wide signed value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] val,
                                                        input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (val > max_v) begin
            return max_v;
        end else if (val < min_v) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer. lb1 holds row r-1, lb2 holds row r-2. Each accept
// at column col shifts that column down one row and stores the new pixel.
// The read port is combinational so the window sees the pre-shift values.
module conv_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    col,
    input  logic [WIDTH-1:0] pixel_in,
    output logic [WIDTH-1:0] row1_out,
    output logic [WIDTH-1:0] row2_out
);

    logic [WIDTH-1:0] lb1 [DEPTH];
    logic [WIDTH-1:0] lb2 [DEPTH];

    assign row1_out = lb1[col];
    assign row2_out = lb2[col];

    // Column shift on accept: row r-1 moves to r-2, new pixel becomes r-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lb1[i] <= '0;
                lb2[i] <= '0;
            end
        end else if (wr_en) begin
            lb2[col] <= lb1[col];
            lb1[col] <= pixel_in;
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 valid convolution, one output channel. Consumes a raster
// frame, emits (W-2)x(H-2) saturated results two clocks after each accept.
// Optional build macro: CONV_RELU_EN clamps negative results to 0.
//
// state    | meaning
// ST_IDLE  | between frames; coefficient writes allowed
// ST_FRAME | frame in progress (busy); coefficient writes ignored
module conv3x3_stream
    import cnn_pkg::*;
#(
    parameter int IMG_WIDTH    = CNN_IMG_W,
    parameter int IMG_HEIGHT   = CNN_IMG_H,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 20,
    parameter int DATA_WIDTH   = CNN_CONV_DW,
    parameter int ACC_WIDTH    = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   valid_in,
    input  logic                   wr_en,
    input  logic [3:0]             wr_addr,
    input  logic [BIAS_WIDTH-1:0]  wr_data,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    output logic                   busy
);

    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int PROD_W = PIXEL_WIDTH + WEIGHT_WIDTH + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic                           accept;
    logic                           last_pix;
    logic                           win_done;
    logic                           coef_we;
    logic [CW-1:0]                  col;
    logic [RW-1:0]                  row;
    conv_state_t                    state;
    conv_state_t                    state_nxt;
    logic [PIXEL_WIDTH-1:0]         lb1_rd;
    logic [PIXEL_WIDTH-1:0]         lb2_rd;
    logic [PIXEL_WIDTH-1:0]         win [3][3];
    logic signed [WEIGHT_WIDTH-1:0] kern [CNN_NUM_TAPS];
    logic signed [BIAS_WIDTH-1:0]   bias;
    logic                           s1_valid;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [DATA_WIDTH-1:0]   result;

    assign accept   = enable && valid_in;
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
    assign win_done = (col >= COL_MIN) && (row >= ROW_MIN);
    assign busy     = (state == ST_FRAME);
    // The first accept of a frame still sees ST_IDLE, so it is excluded
    // explicitly to keep coefficients stable for the whole frame.
    assign coef_we  = wr_en && (state == ST_IDLE) && !accept;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame state next-state: any accept enters/stays in a frame unless it is the last pixel.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = last_pix ? ST_IDLE : ST_FRAME;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    conv_line_buffer #(
        .WIDTH (PIXEL_WIDTH),
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (accept),
        .col      (col),
        .pixel_in (pixel_in),
        .row1_out (lb1_rd),
        .row2_out (lb2_rd)
    );

    // 3x3 window: shift left, load the new column {r-2, r-1, r} on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= pixel_in;
        end
    end

    // Stage-1 qualifier: the window just loaded is a complete valid window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept && win_done;
        end
    end

    // Coefficient register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CNN_NUM_TAPS; i++) begin
                kern[i] <= '0;
            end
            bias <= '0;
        end else if (coef_we) begin
            if (wr_addr < CNN_ADDR_BIAS) begin
                kern[wr_addr] <= wr_data[WEIGHT_WIDTH-1:0];
            end else if (wr_addr == CNN_ADDR_BIAS) begin
                bias <= wr_data;
            end
        end
    end

    // Multiply-accumulate over the window, then saturate (and optionally rectify).
    always_comb begin
        prod = '0;
        acc  = ACC_WIDTH'(bias);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                prod = PROD_W'($signed({1'b0, win[r][c]})) * PROD_W'(kern[r*3 + c]);
                acc  = acc + ACC_WIDTH'(prod);
            end
        end
        result = DATA_WIDTH'(sat_to_width(64'(acc), DATA_WIDTH));
`ifdef CONV_RELU_EN
        if (result < 0) begin
            result = '0;
        end
`endif
    end

    // Stage-2 output register; data holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                data_out <= result;
            end
        end
    end

endmodule
